// File: rtl/sideboard_monitor_pkg.sv
// Shared constants and saturating helpers for the sideboard slow-ADC monitor.
package sideboard_monitor_pkg;

    localparam int unsigned NCH_DEFAULT = 8;
    localparam int unsigned DW_DEFAULT  = 14;

    localparam logic [2:0] CH_I1  = 3'd0;
    localparam logic [2:0] CH_I2  = 3'd1;
    localparam logic [2:0] CH_I3  = 3'd2;
    localparam logic [2:0] CH_V1  = 3'd3;
    localparam logic [2:0] CH_V2  = 3'd4;
    localparam logic [2:0] CH_V3  = 3'd5;
    localparam logic [2:0] CH_J18 = 3'd6;
    localparam logic [2:0] CH_J17 = 3'd7;

    // Replicated across DW: upper limit all ones, lower limit zero, so nothing alarms.
    localparam logic THR_HI_RST_BIT = 1'b1;
    localparam logic THR_LO_RST_BIT = 1'b0;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] limit);
        logic [32:0] total;
        total = {1'b0, a} + {1'b0, b};
        return (total > {1'b0, limit}) ? limit : total[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/sb_window_cmp.sv
// Hysteretic window comparator with sticky latch for one averaged channel.
module sb_window_cmp
    import sideboard_monitor_pkg::*;
#(
    parameter int unsigned DW   = DW_DEFAULT,
    parameter int unsigned HYST = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          eval,
    input  logic [DW-1:0] avg,
    input  logic [DW-1:0] thr_hi,
    input  logic [DW-1:0] thr_lo,
    input  logic          alarm_clr,
    output logic          alarm_live,
    output logic          alarm_sticky
);
    localparam int unsigned DW1     = DW + 1;
    localparam logic [DW:0] SAT_MAX = '1;

    logic [DW:0] avg_x;
    logic [DW:0] rel_lo;
    logic [DW:0] rel_hi;
    logic        set_cond;
    logic        rel_cond;
    logic        live_next;

    always_comb begin
        avg_x     = {1'b0, avg};
        rel_lo    = DW1'(sat_add(32'(thr_lo), HYST, 32'(SAT_MAX)));
        rel_hi    = DW1'(sat_sub(32'(thr_hi), HYST));
        set_cond  = (avg > thr_hi) || (avg < thr_lo);
        // An empty release band (rel_lo > rel_hi) makes rel_cond unreachable.
        rel_cond  = (avg_x >= rel_lo) && (avg_x <= rel_hi);
        live_next = alarm_live;
        if (set_cond) begin
            live_next = 1'b1;
        end else if (rel_cond) begin
            live_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alarm_live   <= 1'b0;
            alarm_sticky <= 1'b0;
        end else begin
            if (eval) begin
                alarm_live <= live_next;
            end
            if (eval && live_next) begin
                alarm_sticky <= 1'b1;
            end else if (alarm_clr) begin
                alarm_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sideboard_monitor.sv
// Per-channel boxcar averager on the gated slow-ADC stream, feeding windowed alarms.
module sideboard_monitor
    import sideboard_monitor_pkg::*;
#(
    parameter int unsigned NCH      = NCH_DEFAULT,
    parameter int unsigned DW       = DW_DEFAULT,
    parameter int unsigned AVG_LOG2 = 4,
    parameter int unsigned HYST     = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] adc_gate,
    input  logic [DW-1:0]  adc_data,
    input  logic           thr_we,
    input  logic [2:0]     thr_addr,
    input  logic [DW-1:0]  thr_hi,
    input  logic [DW-1:0]  thr_lo,
    input  logic           alarm_clr,
    input  logic [2:0]     rd_addr,
    output logic [DW-1:0]  rd_avg,
    output logic [NCH-1:0] avg_valid,
    output logic [NCH-1:0] alarm_live,
    output logic [NCH-1:0] alarm_sticky,
    output logic           alarm_any,
    output logic           gate_collision
);
    localparam int unsigned AW = DW + AVG_LOG2;
    localparam int unsigned CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0]  acc      [NCH];
    logic [CW-1:0]  cnt      [NCH];
    logic [DW-1:0]  avg      [NCH];
    logic [DW-1:0]  thr_hi_r [NCH];
    logic [DW-1:0]  thr_lo_r [NCH];
    logic [NCH-1:0] done;

    logic           accept;
    logic           multi;
    logic           found;
    logic           last;
    logic [SW-1:0]  sel;
    logic [AW-1:0]  sum;

    // Lowest set gate bit wins; the single adder then serves whichever channel that is.
    always_comb begin
        accept = |adc_gate;
        multi  = (adc_gate & (adc_gate - NCH'(1))) != '0;
        found  = 1'b0;
        sel    = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (adc_gate[i] && !found) begin
                sel   = SW'(i);
                found = 1'b1;
            end
        end
        last = (cnt[sel] == CNT_LAST);
        sum  = acc[sel] + AW'(adc_data);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                acc[i]      <= '0;
                cnt[i]      <= '0;
                avg[i]      <= '0;
                thr_hi_r[i] <= {DW{THR_HI_RST_BIT}};
                thr_lo_r[i] <= {DW{THR_LO_RST_BIT}};
            end
            avg_valid      <= '0;
            done           <= '0;
            gate_collision <= 1'b0;
            alarm_any      <= 1'b0;
            rd_avg         <= '0;
        end else begin
            done <= '0;
            if (accept) begin
                if (last) begin
                    acc[sel]       <= '0;
                    cnt[sel]       <= '0;
                    avg[sel]       <= DW'(sum >> AVG_LOG2);
                    avg_valid[sel] <= 1'b1;
                    done[sel]      <= 1'b1;
                end else begin
                    acc[sel] <= sum;
                    cnt[sel] <= cnt[sel] + CW'(1);
                end
            end
            if (multi) begin
                gate_collision <= 1'b1;
            end else if (alarm_clr) begin
                gate_collision <= 1'b0;
            end
            if (thr_we) begin
                thr_hi_r[thr_addr] <= thr_hi;
                thr_lo_r[thr_addr] <= thr_lo;
            end
            alarm_any <= |alarm_sticky;
            rd_avg    <= avg[rd_addr];
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_win
        sb_window_cmp #(
            .DW   (DW),
            .HYST (HYST)
        ) u_win (
            .clk          (clk),
            .rst_n        (rst_n),
            .eval         (done[g]),
            .avg          (avg[g]),
            .thr_hi       (thr_hi_r[g]),
            .thr_lo       (thr_lo_r[g]),
            .alarm_clr    (alarm_clr),
            .alarm_live   (alarm_live[g]),
            .alarm_sticky (alarm_sticky[g])
        );
    end

endmodule

// File: tb/tb_sideboard_monitor.sv
// Bench for sideboard_monitor: directed vectors, a window table and random traffic against a block-average model.
module tb_sideboard_monitor;

    localparam int unsigned BLK = 16;
    localparam int unsigned HY  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  adc_gate;
    logic [13:0] adc_data;
    logic        thr_we;
    logic [2:0]  thr_addr;
    logic [13:0] thr_hi;
    logic [13:0] thr_lo;
    logic        alarm_clr;
    logic [2:0]  rd_addr;
    logic [13:0] rd_avg;
    logic [7:0]  avg_valid;
    logic [7:0]  alarm_live;
    logic [7:0]  alarm_sticky;
    logic        alarm_any;
    logic        gate_collision;

    always #5 clk = ~clk;

    sideboard_monitor #(
        .NCH      (8),
        .DW       (14),
        .AVG_LOG2 (4),
        .HYST     (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .adc_gate       (adc_gate),
        .adc_data       (adc_data),
        .thr_we         (thr_we),
        .thr_addr       (thr_addr),
        .thr_hi         (thr_hi),
        .thr_lo         (thr_lo),
        .alarm_clr      (alarm_clr),
        .rd_addr        (rd_addr),
        .rd_avg         (rd_avg),
        .avg_valid      (avg_valid),
        .alarm_live     (alarm_live),
        .alarm_sticky   (alarm_sticky),
        .alarm_any      (alarm_any),
        .gate_collision (gate_collision)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: running block sums and sample counts, block averages, alarm flags.
    int unsigned m_sum [8];
    int unsigned m_n   [8];
    int unsigned m_avg [8];
    int unsigned m_hi  [8];
    int unsigned m_lo  [8];
    int unsigned m_rd;
    logic [7:0]  m_valid, m_done, m_live, m_sticky;
    logic        m_any, m_coll;

    typedef struct {
        logic [13:0] value;
        logic        exp_live;
        logic        exp_sticky;
    } win_vec_t;

    win_vec_t wt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_sum[i] = 0; m_n[i] = 0; m_avg[i] = 0;
            m_hi[i]  = 16383; m_lo[i] = 0;
        end
        m_rd = 0; m_valid = '0; m_done = '0; m_live = '0; m_sticky = '0;
        m_any = 1'b0; m_coll = 1'b0;
    endtask

    // One clock: predict the post-edge state from current inputs, advance, compare everything.
    task automatic cycle();
        int unsigned n_sum [8];
        int unsigned n_n   [8];
        int unsigned n_avg [8];
        int unsigned n_hi  [8];
        int unsigned n_lo  [8];
        int unsigned n_rd, a;
        logic [7:0]  n_valid, n_done, n_live, n_sticky;
        logic        n_any, n_coll;
        int          k;
        n_sum = m_sum; n_n = m_n; n_avg = m_avg; n_hi = m_hi; n_lo = m_lo;
        n_rd = m_rd; n_valid = m_valid; n_live = m_live; n_sticky = m_sticky;
        n_any = m_any; n_coll = m_coll; n_done = '0;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                n_sum[i] = 0; n_n[i] = 0; n_avg[i] = 0; n_hi[i] = 16383; n_lo[i] = 0;
            end
            n_rd = 0; n_valid = '0; n_live = '0; n_sticky = '0; n_any = 1'b0; n_coll = 1'b0;
        end else begin
            n_rd  = m_avg[rd_addr];
            n_any = |m_sticky;
            if (adc_gate != 8'h00) begin
                k = 0;
                for (int i = 7; i >= 0; i--) if (adc_gate[i]) k = i;
                n_sum[k] += 32'(adc_data);
                n_n[k]++;
                if (n_n[k] == BLK) begin
                    n_avg[k] = n_sum[k] / BLK;
                    n_valid[k] = 1'b1; n_done[k] = 1'b1;
                    n_sum[k] = 0; n_n[k] = 0;
                end
            end
            if ($countones(adc_gate) > 1) n_coll = 1'b1;
            else if (alarm_clr) n_coll = 1'b0;
            for (int c = 0; c < 8; c++) begin
                if (m_done[c]) begin
                    a = m_avg[c];
                    if (a > m_hi[c] || a < m_lo[c]) n_live[c] = 1'b1;
                    else if (a >= m_lo[c] + HY && a + HY <= m_hi[c]) n_live[c] = 1'b0;
                end
                if (m_done[c] && n_live[c]) n_sticky[c] = 1'b1;
                else if (alarm_clr) n_sticky[c] = 1'b0;
            end
            if (thr_we) begin
                n_hi[thr_addr] = 32'(thr_hi);
                n_lo[thr_addr] = 32'(thr_lo);
            end
        end
        @(posedge clk);
        #1;
        m_sum = n_sum; m_n = n_n; m_avg = n_avg; m_hi = n_hi; m_lo = n_lo;
        m_rd = n_rd; m_valid = n_valid; m_done = n_done; m_live = n_live;
        m_sticky = n_sticky; m_any = n_any; m_coll = n_coll;
        chk("avg_valid", 32'(avg_valid), 32'(m_valid));
        chk("alarm_live", 32'(alarm_live), 32'(m_live));
        chk("alarm_sticky", 32'(alarm_sticky), 32'(m_sticky));
        chk("alarm_any", 32'(alarm_any), 32'(m_any));
        chk("gate_collision", 32'(gate_collision), 32'(m_coll));
        chk("rd_avg", 32'(rd_avg), m_rd);
    endtask

    task automatic send(input logic [7:0] g, input logic [13:0] d);
        adc_gate = g;
        adc_data = d;
        cycle();
        adc_gate = '0;
        adc_data = 14'($urandom);
    endtask

    task automatic idle(input int n);
        adc_gate = '0;
        repeat (n) cycle();
    endtask

    task automatic wr_thr(input logic [2:0] ch, input logic [13:0] hi, input logic [13:0] lo);
        thr_we = 1'b1; thr_addr = ch; thr_hi = hi; thr_lo = lo;
        cycle();
        thr_we = 1'b0;
    endtask

    task automatic clr_pulse();
        alarm_clr = 1'b1;
        cycle();
        alarm_clr = 1'b0;
    endtask

    initial begin
        // Thresholds 2000/1000 on channel 3: release band is 1016..1984.
        wt[0] = '{14'd2001, 1'b1, 1'b1};
        wt[1] = '{14'd1990, 1'b1, 1'b1};
        wt[2] = '{14'd1984, 1'b0, 1'b1};
        wt[3] = '{14'd1985, 1'b0, 1'b1};
        wt[4] = '{14'd999,  1'b1, 1'b1};
        wt[5] = '{14'd1015, 1'b1, 1'b1};
        wt[6] = '{14'd1016, 1'b0, 1'b1};

        rst_n = 1'b0; adc_gate = '0; adc_data = '0; thr_we = 1'b0; thr_addr = '0;
        thr_hi = '0; thr_lo = '0; alarm_clr = 1'b0; rd_addr = '0;
        model_reset();
        idle(2);
        chk("reset_avg_valid", 32'(avg_valid), 32'h0);
        chk("reset_rd_avg", 32'(rd_avg), 32'h0);
        chk("reset_alarm_any", 32'(alarm_any), 32'h0);
        rst_n = 1'b1;
        idle(1);

        // Channel 2 block of constant 1000.
        rd_addr = 3'd2;
        for (int s = 0; s < 15; s++) send(8'h04, 14'd1000);
        chk("ch2_not_yet_valid", 32'(avg_valid), 32'h0);
        send(8'h04, 14'd1000);
        chk("ch2_valid", 32'(avg_valid), 32'h04);
        idle(1);
        chk("ch2_avg", 32'(rd_avg), 32'd1000);

        // Interleaved ch0 ramp 0..15 and ch5 full scale.
        for (int s = 0; s < 16; s++) begin
            send(8'h01, 14'(s));
            send(8'h20, 14'd16383);
        end
        rd_addr = 3'd0;
        idle(1);
        chk("ch0_avg_trunc", 32'(rd_avg), 32'd7);
        rd_addr = 3'd5;
        idle(1);
        chk("ch5_avg_full", 32'(rd_avg), 32'd16383);
        chk("valid_025", 32'(avg_valid), 32'h25);

        // Window table on channel 3.
        wr_thr(3'd3, 14'd2000, 14'd1000);
        rd_addr = 3'd3;
        for (int i = 0; i < 7; i++) begin
            for (int s = 0; s < 16; s++) send(8'h08, 14'(wt[i].value + 14'(s % 2)));
            idle(1);
            chk($sformatf("win%0d_live", i), 32'(alarm_live[3]), 32'(wt[i].exp_live));
            chk($sformatf("win%0d_sticky", i), 32'(alarm_sticky[3]), 32'(wt[i].exp_sticky));
            chk($sformatf("win%0d_avg", i), 32'(rd_avg), 32'(wt[i].value));
            if (i == 0) begin
                chk("win0_any_delayed", 32'(alarm_any), 32'h0);
                idle(1);
                chk("win0_any", 32'(alarm_any), 32'h1);
            end
        end

        // Clear coinciding with an alarm set on channel 1: set wins.
        wr_thr(3'd1, 14'd100, 14'd0);
        for (int s = 0; s < 16; s++) send(8'h02, 14'd500);
        clr_pulse();
        chk("ch1_set_beats_clr", 32'(alarm_sticky[1]), 32'h1);
        chk("ch1_live", 32'(alarm_live[1]), 32'h1);
        clr_pulse();
        chk("clr_sticky", 32'(alarm_sticky), 32'h0);
        idle(1);
        chk("clr_any", 32'(alarm_any), 32'h0);

        // Two gate bits at once.
        send(8'h24, 14'd500);
        chk("collision_set", 32'(gate_collision), 32'h1);
        clr_pulse();
        chk("collision_clr", 32'(gate_collision), 32'h0);

        // Reset mid-block on channel 4 discards partial data.
        for (int s = 0; s < 7; s++) send(8'h10, 14'd9000);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("midreset_valid", 32'(avg_valid), 32'h0);
        rd_addr = 3'd4;
        for (int s = 0; s < 16; s++) send(8'h10, 14'd300);
        idle(1);
        chk("ch4_avg_after_reset", 32'(rd_avg), 32'd300);
        chk("ch4_no_live", 32'(alarm_live), 32'h0);
        chk("ch4_no_sticky", 32'(alarm_sticky), 32'h0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r < 3) adc_gate = '0;
            else if (r < 9) adc_gate = 8'(1 << $urandom_range(0, 7));
            else adc_gate = 8'($urandom);
            adc_data  = 14'($urandom);
            thr_we    = ($urandom_range(0, 49) == 0);
            thr_addr  = 3'($urandom);
            thr_lo    = 14'($urandom_range(4000, 8200));
            thr_hi    = 14'($urandom_range(8000, 12000));
            alarm_clr = ($urandom_range(0, 29) == 0);
            rd_addr   = 3'($urandom);
            rst_n     = ($urandom_range(0, 999) != 0);
            cycle();
        end
        rst_n = 1'b1; adc_gate = '0; thr_we = 1'b0; alarm_clr = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sideboard_monitor.md
Name: sideboard_monitor

Overview:
- Consumes the gated 14-bit slow-ADC sample stream from the sideboard SPI demux: adc1_gate one-hot strobe plus adc1_data.
- Boxcar-averages each of 8 channels (I/V bias chans 1-3, J17/J18) and window-compares each average against programmable thresholds with hysteresis.
- Raises live and sticky per-channel alarms for the interlock/readout path.
- Sits directly downstream of the demux, in parallel with the sideboard's raw voltage registers.

Parameters:
NCH, 8, number of gated channels (one gate bit each)
DW, 14, sample and average width, unsigned offset binary
AVG_LOG2, 4, log2 of samples per boxcar block (valid range 0..8)
HYST, 16, hysteresis margin in LSBs for alarm release

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
adc_gate  in  NCH  one-hot sample strobe; bit k means adc_data belongs to channel k
adc_data  in  DW  sample value, valid only when adc_gate is nonzero
thr_we  in  1  threshold write strobe
thr_addr  in  3  channel for threshold write
thr_hi  in  DW  upper limit written on thr_we
thr_lo  in  DW  lower limit written on thr_we
alarm_clr  in  1  clears all sticky alarms and the collision flag
rd_addr  in  3  readout channel select
rd_avg  out  DW  latest average of channel rd_addr, registered
avg_valid  out  NCH  bit k set once channel k has completed its first block
alarm_live  out  NCH  current hysteretic out-of-window state
alarm_sticky  out  NCH  latched alarm, held until alarm_clr
alarm_any  out  1  OR of alarm_sticky
gate_collision  out  1  sticky flag: more than one adc_gate bit was seen in one cycle

Behaviour:
- Reset (rst_n=0 at a clk edge): all accumulators, sample counters, averages, avg_valid, alarm_live, alarm_sticky, gate_collision and rd_avg go to 0. thr_hi resets to all ones and thr_lo to 0, so no alarm can fire. Reset mid-block discards the partial accumulation.
- Sample accept, cycle t: if adc_gate is nonzero, select the lowest set bit k. If more than one bit is set, the higher bits are dropped and gate_collision is set.
- Accumulate: acc[k] += adc_data. acc width is DW+AVG_LOG2, so it cannot overflow. cnt[k] increments modulo 2^AVG_LOG2. Result is registered at t+1.
- Block completion: when the accepted sample is sample number 2^AVG_LOG2 of the block (cnt wraps to 0):
  - avg[k] = (acc + sample) >> AVG_LOG2, truncating; avg[k] and avg_valid[k] update at t+1.
  - acc[k] restarts at 0 and the following sample begins a new block.
  - AVG_LOG2=0 means every sample is an average.
- One adder is shared by all channels; the accepted input is one-hot, so there are no resource conflicts.
- Compare at t+2, only for channels that completed a block at t+1:
  - Set: avg > thr_hi or avg < thr_lo.
  - Release: thr_lo+HYST <= avg <= thr_hi-HYST, computed with DW+1-bit saturating arithmetic. If thr_lo+HYST > thr_hi-HYST, alarm_live never releases.
  - Otherwise alarm_live holds its previous value.
- Sticky: alarm_sticky[k] is set whenever alarm_live[k] is 1 at the evaluation cycle. alarm_clr clears all sticky bits and gate_collision. If a set and alarm_clr occur in the same cycle, set wins.
- alarm_any is registered: OR of alarm_sticky, one cycle later.
- Threshold write: thr_we loads thr_hi/thr_lo[thr_addr] at the next edge. The new value is used from the next evaluation; an in-flight evaluation in the same cycle uses the old value. Writes do not re-evaluate the existing avg.
- Readout: rd_avg = avg[rd_addr], one-cycle registered latency.
- adc_data is ignored when adc_gate==0.

Decomposition:
- Package sideboard_monitor_pkg holds:
  - NCH/DW defaults
  - the channel index constants (CH_I1..CH_I3, CH_V1..CH_V3, CH_J18, CH_J17)
  - the threshold-reset constants
  - the saturating-add helper function
- One sub-module, sb_window_cmp: per-channel hysteretic comparator plus sticky latch, instantiated NCH times.
- The averager, the shared adder and the priority select stay in the top module.

Test Plan:
- Feed AVG_LOG2=4 on channel 2 with 16 samples of 1000 -> avg_valid[2] rises 1 cycle after the 16th gate; rd_avg(rd_addr=2)=1000; other channels stay at 0/invalid.
- Channel 0 samples 0..15 (sum 120), interleaved with channel 5 samples of 16383 -> avg0=7 (truncated), avg5=16383; no cross-contamination.
- Set thr_hi[3]=2000, thr_lo[3]=1000, HYST=16:
  - block avg 2001 -> alarm_live[3] and alarm_sticky[3] at t+2, alarm_any one cycle later;
  - block avg 1990 -> alarm_live stays 1;
  - block avg 1984 -> alarm_live clears, sticky stays 1.
- Pulse alarm_clr in the same cycle an alarm sets on channel 1 -> alarm_sticky[1]=1. Pulse alarm_clr alone later -> sticky=0, alarm_any=0.
- adc_gate=8'b0010_0100 with data 500 -> only channel 2 accumulates, gate_collision=1. alarm_clr clears gate_collision.
- Assert rst_n=0 after 7 of 16 samples on channel 4, release, then feed 16 samples of 300 -> avg4=300 (partial data discarded); thresholds back to defaults, no alarms.
